// File: rtl/sram_key_responder_if.sv
// Key request/acknowledge bundle between the SRAM-side requester and the OTP key responder.
interface sram_key_responder_if #(
  parameter int KeyWidth   = 128,
  parameter int NonceWidth = 64
);
  logic                  req_i;
  logic                  ack_o;
  logic [KeyWidth-1:0]   key_seed_i;
  logic                  seed_valid_i;
  logic                  escalate_i;
  logic [KeyWidth-1:0]   key_o;
  logic [NonceWidth-1:0] nonce_o;
  logic                  seed_valid_o;
  logic                  busy_o;

  modport master (
    output req_i, key_seed_i, seed_valid_i, escalate_i,
    input  ack_o, key_o, nonce_o, seed_valid_o, busy_o
  );

  modport slave (
    input  req_i, key_seed_i, seed_valid_i, escalate_i,
    output ack_o, key_o, nonce_o, seed_valid_o, busy_o
  );
endinterface

// File: rtl/sram_key_responder.sv
// OTP-side responder: derives a scrambling key/nonce per request from the OTP seed and a
// free-running LFSR nonce; escalation latches the default constants permanently.
module sram_key_responder #(
  parameter int                 KeyWidth        = 128,
  parameter int                 NonceWidth      = 64,
  parameter int                 Rounds          = 4,
  parameter logic [63:0]        RndCnstLfsrSeed = 64'hA5A5_0F0F_C3C3_1234,
  parameter logic [127:0]       RndCnstKey      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter logic [63:0]        RndCnstNonce    = 64'hDEAD_BEEF_CAFE_F00D
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sram_key_responder_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DERIVE   = 3'd1;
  localparam logic [2:0] ACK      = 3'd2;
  localparam logic [2:0] WAIT_LOW = 3'd3;
  localparam logic [2:0] ESC      = 3'd4;

  localparam logic [3:0] LastRound = 4'(Rounds - 1);

  logic [2:0]            state, state_n;
  logic [NonceWidth-1:0] lfsr, lfsr_next;
  logic [NonceWidth-1:0] nonce_q;
  logic [KeyWidth-1:0]   st, st_next, st_init;
  logic                  sv_q;
  logic [3:0]            rcnt;
  logic                  esc_q, esc_now;
  logic                  acked;
  logic                  ack;
  logic [KeyWidth-1:0]   key;
  logic [NonceWidth-1:0] nonce;
  logic                  seed_valid;
  logic                  load, step, finish, esc_ack, enter_esc;

  assign lfsr_next = {lfsr[NonceWidth-2:0],
                      lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

  assign st_init = (bus.seed_valid_i ? bus.key_seed_i : RndCnstKey) ^ {lfsr, lfsr};
  assign st_next = {st[KeyWidth-14:0], st[KeyWidth-1:KeyWidth-13]}
                   ^ {nonce_q, ~nonce_q} ^ {{(KeyWidth-4){1'b0}}, rcnt};

  // Escalation takes effect in the very cycle it is first seen, not only once latched.
  assign esc_now = esc_q | bus.escalate_i;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (esc_now) begin
          state_n = ESC;
        end else if (bus.req_i) begin
          state_n = DERIVE;
          load    = 1'b1;
        end
      end
      DERIVE: begin
        if (esc_now) begin
          state_n = ESC;
        end else begin
          step = 1'b1;
          if (rcnt == LastRound) begin
            state_n = ACK;
            finish  = 1'b1;
          end
        end
      end
      ACK:      state_n = esc_now ? ESC : WAIT_LOW;
      WAIT_LOW: begin
        if (esc_now) state_n = ESC;
        else if (!bus.req_i) state_n = IDLE;
      end
      ESC:      state_n = ESC;
      default:  state_n = IDLE;
    endcase
  end

  // acked marks a request level that has already been answered, so a held request
  // never collects a second ack, even across the switch into ESC.
  assign esc_ack   = (state == ESC) && bus.req_i && !acked && !ack;
  assign enter_esc = (state != ESC) && (state_n == ESC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lfsr       <= RndCnstLfsrSeed;
      esc_q      <= 1'b0;
      acked      <= 1'b0;
      rcnt       <= '0;
      ack        <= 1'b0;
      key        <= RndCnstKey;
      nonce      <= RndCnstNonce;
      seed_valid <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_next;
      esc_q <= esc_now;
      ack   <= finish | esc_ack;
      if (finish | esc_ack) acked <= bus.req_i;
      else if (!bus.req_i)  acked <= 1'b0;
      if (load)      rcnt <= '0;
      else if (step) rcnt <= rcnt + 4'd1;
      if (enter_esc) begin
        key        <= RndCnstKey;
        nonce      <= RndCnstNonce;
        seed_valid <= 1'b0;
      end else if (finish) begin
        key        <= st_next;
        nonce      <= nonce_q;
        seed_valid <= sv_q;
      end
    end
  end

  // Derivation datapath carries no reset; it is always reloaded on request acceptance.
  always_ff @(posedge clk_i) begin
    if (load) begin
      nonce_q <= lfsr;
      st      <= st_init;
      sv_q    <= bus.seed_valid_i;
    end else if (step) begin
      st <= st_next;
    end
  end

  assign bus.ack_o        = ack;
  assign bus.key_o        = key;
  assign bus.nonce_o      = nonce;
  assign bus.seed_valid_o = seed_valid;
  assign bus.busy_o       = (state != IDLE) && (state != ESC);

endmodule

// File: tb/tb_sram_key_responder.sv
// Scoreboard bench: three responders (Rounds 4, 1, 15) share one request stream; expected
// acks are queued at issue time and checked by an independent monitor.
module tb_sram_key_responder;

  localparam logic [63:0]  SEED  = 64'hA5A5_0F0F_C3C3_1234;
  localparam logic [127:0] DKEY  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DNON  = 64'hDEAD_BEEF_CAFE_F00D;

  typedef struct {
    int           cyc;
    logic [127:0] key;
    logic [63:0]  nonce;
    logic         sv;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [127:0] key_seed = '0;
  logic         seed_valid = 1'b0;
  logic         escalate = 1'b0;

  logic [2:0]   ack_v, busy_v, sv_v;
  logic [127:0] key_v [3];
  logic [63:0]  nonce_v [3];

  int           cyc = 0;
  logic [63:0]  lfsr_m = SEED;
  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int R = (g == 0) ? 4 : (g == 1) ? 1 : 15;
    sram_key_responder_if ifc ();
    assign ifc.req_i        = req;
    assign ifc.key_seed_i   = key_seed;
    assign ifc.seed_valid_i = seed_valid;
    assign ifc.escalate_i   = escalate;
    assign ack_v[g]         = ifc.ack_o;
    assign busy_v[g]        = ifc.busy_o;
    assign sv_v[g]          = ifc.seed_valid_o;
    assign key_v[g]         = ifc.key_o;
    assign nonce_v[g]       = ifc.nonce_o;
    sram_key_responder #(.Rounds(R)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc.slave)
    );
  end

  function automatic int rnd(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 15;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [127:0] golden(input logic [127:0] base, input logic [63:0] n,
                                          input int r);
    logic [127:0] s;
    s = base ^ {n, n};
    for (int i = 0; i < r; i++) s = {s[114:0], s[127:115]} ^ {n, ~n} ^ 128'(i);
    return s;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= rst ? SEED : lfsr_step(lfsr_m);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int g, output logic have, output exp_t e);
    have = 1'b0;
    e    = '{0, '0, '0, 1'b0};
    case (g)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
  endtask

  // Monitor: every observed ack consumes one expectation for that instance.
  always @(negedge clk) begin : mon
    exp_t e;
    logic have;
    for (int g = 0; g < 3; g++) begin
      if (ack_v[g] === 1'b1) begin
        pop(g, have, e);
        if (!have) begin
          chk($sformatf("r%0d_unexpected_ack_cyc%0d", rnd(g), cyc), 1, 0);
        end else begin
          chk($sformatf("r%0d_ack_cycle", rnd(g)), 128'(cyc), 128'(e.cyc));
          chk($sformatf("r%0d_key", rnd(g)), key_v[g], e.key);
          chk($sformatf("r%0d_nonce", rnd(g)), 128'(nonce_v[g]), 128'(e.nonce));
          chk($sformatf("r%0d_seed_valid", rnd(g)), 128'(sv_v[g]), 128'(e.sv));
        end
      end
    end
  end

  task automatic check_defaults(input string tag, input logic [2:0] busy_exp);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_r%0d_ack", tag, rnd(g)), 128'(ack_v[g]), 0);
      chk($sformatf("%s_r%0d_key", tag, rnd(g)), key_v[g], DKEY);
      chk($sformatf("%s_r%0d_nonce", tag, rnd(g)), 128'(nonce_v[g]), 128'(DNON));
      chk($sformatf("%s_r%0d_sv", tag, rnd(g)), 128'(sv_v[g]), 0);
      chk($sformatf("%s_r%0d_busy", tag, rnd(g)), 128'(busy_v[g]), 128'(busy_exp[g]));
    end
  endtask

  task automatic start_req(input logic sv, input logic [127:0] seed,
                           output int t, output logic [63:0] n);
    @(negedge clk);
    seed_valid = sv;
    key_seed   = seed;
    req        = 1'b1;
    t          = cyc + 1;
    n          = lfsr_m;
  endtask

  task automatic normal_req(input logic sv, input logic [127:0] seed, input int hold);
    int          t;
    logic [63:0] n;
    chk("pre_req_busy", 128'(busy_v), 0);
    start_req(sv, seed, t, n);
    for (int g = 0; g < 3; g++)
      push(g, '{t + rnd(g), golden(sv ? seed : DKEY, n, rnd(g)), n, sv});
    @(negedge clk);
    chk("busy_after_accept", 128'(busy_v), 128'(3'b111));
    // Inputs after acceptance must not influence the derivation.
    key_seed   = ~seed;
    seed_valid = ~sv;
    repeat (5) @(negedge clk);
    chk("r4_busy_wait_low", 128'(busy_v[0]), 1);
    repeat (11 + hold) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_after_drop", 128'(busy_v), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          t;
    logic [63:0] n;

    repeat (2) @(negedge clk);
    check_defaults("reset", 3'b000);
    rst = 1'b0;
    repeat (7) @(negedge clk);

    normal_req(1'b1, '0, 20);
    normal_req(1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
    normal_req(1'b1, 128'hCAFE_BABE_0000_FFFF_1234_5678_9ABC_DEF0, 3);

    // Reset one cycle after acceptance: no instance may acknowledge.
    start_req(1'b1, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, t, n);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_defaults("mid_reset", 3'b000);
    repeat (3) @(negedge clk);
    normal_req(1'b1, 128'hFEED_FACE_0BAD_F00D_DEAD_10CC_8BAD_F00D, 0);

    // Escalation pulse two cycles into the derivation.
    start_req(1'b1, 128'h0F0F_F0F0_3C3C_C3C3_6969_9696_A5A5_5A5A, t, n);
    push(0, '{t + 3, DKEY, DNON, 1'b0});
    push(1, '{t + 1, golden(128'h0F0F_F0F0_3C3C_C3C3_6969_9696_A5A5_5A5A, n, 1), n, 1'b1});
    push(2, '{t + 3, DKEY, DNON, 1'b0});
    @(negedge clk);
    @(negedge clk);
    escalate = 1'b1;
    @(negedge clk);
    escalate = 1'b0;
    repeat (4) @(negedge clk);
    check_defaults("esc_hold", 3'b000);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    seed_valid = 1'b1;
    t = cyc + 1;
    for (int g = 0; g < 3; g++) push(g, '{t, DKEY, DNON, 1'b0});
    repeat (6) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Request and escalation arriving together from IDLE.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_defaults("reset2", 3'b000);
    repeat (3) @(negedge clk);
    req      = 1'b1;
    escalate = 1'b1;
    t = cyc + 1;
    for (int g = 0; g < 3; g++) push(g, '{t + 1, DKEY, DNON, 1'b0});
    @(negedge clk);
    escalate = 1'b0;
    repeat (5) @(negedge clk);
    chk("esc_busy", 128'(busy_v), 0);
    req = 1'b0;
    repeat (20) @(negedge clk);

    chk("r4_pending", 128'(q0.size()), 0);
    chk("r1_pending", 128'(q1.size()), 0);
    chk("r15_pending", 128'(q2.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
